// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between two requesters. Accepts one
//            operation at a time (round-robin on contention), drives the ALU
//            from latched operands, captures result/zero into a response
//            register and returns it to the issuing requester.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_ctrl,
  output logic                  req0_ready,
  // requester 1
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_ctrl,
  output logic                  req1_ready,
  // responses
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  input  logic                  rsp0_ready,
  input  logic                  rsp1_ready,
  // shared ALU
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;  // id of the most recently granted requester
  logic                  r_gid;         // id of the requester owning the current op
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [2:0]            r_ctrl;

  logic w_idle;
  logic w_any_valid;
  logic w_gid;
  logic w_rsp_done;

  // Grant selection: a lone requester wins; on contention the requester that
  // was not granted last time wins, giving strict alternation.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_gid = ~r_last_grant;
    end else begin
      w_gid = req1_valid;
    end
  end

  assign req0_ready = w_idle & w_any_valid & ~w_gid;
  assign req1_ready = w_idle & w_any_valid &  w_gid;

  // Response channel belongs to whoever issued the op; the other ready is ignored.
  assign rsp0_valid = (r_state == S_RESP) & ~r_gid;
  assign rsp1_valid = (r_state == S_RESP) &  r_gid;
  assign w_rsp_done = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  // ALU is always driven from the latched registers so its inputs only move
  // when a new operation is accepted.
  assign alu_op1  = r_op1;
  assign alu_op2  = r_op2;
  assign alu_ctrl = r_ctrl;
  assign busy     = (r_state != S_IDLE);

  // Control FSM plus operand latch and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gid        <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_ctrl       <= 3'd0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_op1        <= w_gid ? req1_op1  : req0_op1;
            r_op2        <= w_gid ? req1_op2  : req0_op2;
            r_ctrl       <= w_gid ? req1_ctrl : req0_ctrl;
            r_gid        <= w_gid;
            r_last_grant <= w_gid;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
